// File: rtl/uart_fifo_lvl_pkg.sv
// Shared constants and helpers for the UART FIFO family.
package uart_fifo_pkg;

    localparam int unsigned DefWordLength     = 8;
    localparam int unsigned DefDepth          = 16;
    localparam int unsigned DefAlmostEmptyThr = 2;

    // Width needed to hold an occupancy count of 0..depth.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth + 32'd1);
    endfunction

    // Advance a pointer, wrapping from depth-1 back to 0 for any depth.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/uart_fifo_lvl_if.sv
// Queue-side bus for uart_fifo_lvl: requests/data in, status and head word out.
interface uart_fifo_lvl_if #(
    parameter int unsigned WordLength = 8,
    parameter int unsigned Depth      = 16
) ();
    localparam int unsigned LvlW = uart_fifo_pkg::lvl_w(Depth);

    logic                  clr_i;
    logic                  wr_i;
    logic [WordLength-1:0] w_data_i;
    logic                  rd_i;
    logic [WordLength-1:0] r_data_o;
    logic                  empty_o;
    logic                  full_o;
    logic                  almost_empty_o;
    logic                  almost_full_o;
    logic [LvlW-1:0]       level_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output clr_i, wr_i, w_data_i, rd_i,
        input  r_data_o, empty_o, full_o, almost_empty_o, almost_full_o,
               level_o, overflow_o, underflow_o
    );

    modport slave (
        input  clr_i, wr_i, w_data_i, rd_i,
        output r_data_o, empty_o, full_o, almost_empty_o, almost_full_o,
               level_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/uart_fifo_lvl_mem.sv
// Storage array for uart_fifo_lvl: one synchronous write port, one asynchronous read port.
module uart_fifo_mem #(
    parameter int unsigned WordLength = 8,
    parameter int unsigned Depth      = 16
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(Depth)-1:0]      w_addr,
    input  logic [WordLength-1:0]         w_data,
    input  logic [$clog2(Depth)-1:0]      r_addr,
    output logic [WordLength-1:0]         r_data
);
    logic [WordLength-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];
endmodule

// File: rtl/uart_fifo_lvl.sv
// First-word fall-through FIFO with occupancy level, almost flags, flush and sticky errors.
module uart_fifo_lvl
    import uart_fifo_pkg::*;
#(
    parameter int unsigned WordLength     = DefWordLength,
    parameter int unsigned Depth          = DefDepth,
    parameter int unsigned AlmostFullThr  = Depth - 2,
    parameter int unsigned AlmostEmptyThr = DefAlmostEmptyThr
) (
    input  logic           clk,
    input  logic           rst,
    uart_fifo_lvl_if.slave bus
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = lvl_w(Depth);

    if (WordLength < 1) begin : g_bad_width
        $error("uart_fifo_lvl: WordLength must be >= 1");
    end
    if (Depth < 2) begin : g_bad_depth
        $error("uart_fifo_lvl: Depth must be >= 2");
    end
    if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_bad_af
        $error("uart_fifo_lvl: AlmostFullThr must be in 1..Depth");
    end
    if (AlmostEmptyThr > Depth - 1) begin : g_bad_ae
        $error("uart_fifo_lvl: AlmostEmptyThr must be in 0..Depth-1");
    end

    logic [PtrW-1:0] w_ptr, r_ptr, w_ptr_next, r_ptr_next;
    logic [LvlW-1:0] level, level_next;
    logic            empty, full, almost_empty, almost_full, overflow, underflow;
    logic            wr_acc, rd_acc, ovf_set, unf_set;

    // Acceptance, error detection and next occupancy; clr masks all requests.
    always_comb begin
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        level_next = level;
        w_ptr_next = w_ptr;
        r_ptr_next = r_ptr;
        if (bus.clr_i) begin
            level_next = '0;
            w_ptr_next = '0;
            r_ptr_next = '0;
        end else begin
            rd_acc  = bus.rd_i & ~empty;
            wr_acc  = bus.wr_i & (~full | bus.rd_i);
            ovf_set = bus.wr_i & ~wr_acc;
            unf_set = bus.rd_i & ~rd_acc;
            if (wr_acc) begin
                w_ptr_next = PtrW'(ptr_inc(32'(w_ptr), Depth));
            end
            if (rd_acc) begin
                r_ptr_next = PtrW'(ptr_inc(32'(r_ptr), Depth));
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_next = level + LvlW'(1);
                2'b01:   level_next = level - LvlW'(1);
                default: level_next = level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr        <= '0;
            r_ptr        <= '0;
            level        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            w_ptr        <= w_ptr_next;
            r_ptr        <= r_ptr_next;
            level        <= level_next;
            empty        <= (level_next == '0);
            full         <= (level_next == LvlW'(Depth));
            almost_empty <= (level_next <= LvlW'(AlmostEmptyThr));
            almost_full  <= (level_next >= LvlW'(AlmostFullThr));
            overflow     <= bus.clr_i ? 1'b0 : (overflow | ovf_set);
            underflow    <= bus.clr_i ? 1'b0 : (underflow | unf_set);
        end
    end

    uart_fifo_mem #(
        .WordLength (WordLength),
        .Depth      (Depth)
    ) u_mem (
        .clk    (clk),
        .we     (wr_acc),
        .w_addr (w_ptr),
        .w_data (bus.w_data_i),
        .r_addr (r_ptr),
        .r_data (bus.r_data_o)
    );

    assign bus.level_o        = level;
    assign bus.empty_o        = empty;
    assign bus.full_o         = full;
    assign bus.almost_empty_o = almost_empty;
    assign bus.almost_full_o  = almost_full;
    assign bus.overflow_o     = overflow;
    assign bus.underflow_o    = underflow;
endmodule

// File: tb/tb_uart_fifo_lvl.sv
// Bench for uart_fifo_lvl: Depth=16 and Depth=5 instances against a queue model plus literal checks.
module tb_uart_fifo_lvl;

    logic clk;
    logic rst;
    logic       s_wr  [2];
    logic       s_rd  [2];
    logic       s_clr [2];
    logic [7:0] s_wd  [2];

    int ntests = 0;
    int nfail  = 0;

    // Behavioural model: index 0 is the Depth=16 FIFO, index 1 the Depth=5 FIFO.
    logic [7:0] mq [2][16];
    int         mcnt [2];
    bit         movf [2];
    bit         munf [2];

    uart_fifo_lvl_if #(.WordLength(8), .Depth(16)) if16 ();
    uart_fifo_lvl_if #(.WordLength(8), .Depth(5))  if5  ();

    assign if16.wr_i     = s_wr[0];
    assign if16.rd_i     = s_rd[0];
    assign if16.clr_i    = s_clr[0];
    assign if16.w_data_i = s_wd[0];
    assign if5.wr_i      = s_wr[1];
    assign if5.rd_i      = s_rd[1];
    assign if5.clr_i     = s_clr[1];
    assign if5.w_data_i  = s_wd[1];

    uart_fifo_lvl #(.WordLength(8), .Depth(16), .AlmostFullThr(14), .AlmostEmptyThr(2)) u16 (
        .clk (clk), .rst (rst), .bus (if16.slave)
    );
    uart_fifo_lvl #(.WordLength(8), .Depth(5), .AlmostFullThr(3), .AlmostEmptyThr(2)) u5 (
        .clk (clk), .rst (rst), .bus (if5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mstep(input int i);
        int  dep;
        bit  rok, wok;
        dep = (i == 0) ? 16 : 5;
        if (s_clr[i]) begin
            mcnt[i] = 0;
            movf[i] = 0;
            munf[i] = 0;
        end else begin
            rok = s_rd[i] && (mcnt[i] > 0);
            wok = s_wr[i] && ((mcnt[i] < dep) || rok);
            if (s_wr[i] && !wok) movf[i] = 1;
            if (s_rd[i] && !rok) munf[i] = 1;
            if (rok) begin
                for (int k = 0; k < 15; k++) mq[i][k] = mq[i][k+1];
                mcnt[i]--;
            end
            if (wok) begin
                mq[i][mcnt[i]] = s_wd[i];
                mcnt[i]++;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mcnt[i] = 0;
                movf[i] = 0;
                munf[i] = 0;
            end
        end else begin
            mstep(0);
            mstep(1);
        end
    end

    task automatic cmp(input int i, input logic [7:0] rdat, input logic [31:0] lvl,
                       input logic e, input logic f, input logic ae, input logic af,
                       input logic o, input logic u);
        int dep;
        int afthr;
        string p;
        dep   = (i == 0) ? 16 : 5;
        afthr = dep - 2;
        p     = (i == 0) ? "d16" : "d5";
        chk({p, ".level"}, lvl, 32'(mcnt[i]));
        chk({p, ".empty"}, 32'(e), 32'(mcnt[i] == 0));
        chk({p, ".full"},  32'(f), 32'(mcnt[i] == dep));
        chk({p, ".aempty"}, 32'(ae), 32'(mcnt[i] <= 2));
        chk({p, ".afull"},  32'(af), 32'(mcnt[i] >= afthr));
        chk({p, ".ovf"}, 32'(o), 32'(movf[i]));
        chk({p, ".unf"}, 32'(u), 32'(munf[i]));
        if (mcnt[i] > 0) chk({p, ".rdata"}, 32'(rdat), 32'(mq[i][0]));
    endtask

    // Every falling edge out of reset: both DUTs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            cmp(0, if16.r_data_o, 32'(if16.level_o), if16.empty_o, if16.full_o,
                if16.almost_empty_o, if16.almost_full_o, if16.overflow_o, if16.underflow_o);
            cmp(1, if5.r_data_o, 32'(if5.level_o), if5.empty_o, if5.full_o,
                if5.almost_empty_o, if5.almost_full_o, if5.overflow_o, if5.underflow_o);
        end
    end

    // Drive one cycle on both FIFOs; returns just after the edge that consumed it.
    task automatic drv(input logic w0, input logic r0, input logic c0, input logic [7:0] d0,
                       input logic w1, input logic r1, input logic c1, input logic [7:0] d1);
        s_wr[0] = w0; s_rd[0] = r0; s_clr[0] = c0; s_wd[0] = d0;
        s_wr[1] = w1; s_rd[1] = r1; s_clr[1] = c1; s_wd[1] = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic d16(input logic w, input logic r, input logic c, input logic [7:0] d);
        drv(w, r, c, d, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic chk_reset16(input string tag);
        chk({tag, ".level"},  32'(if16.level_o), 32'd0);
        chk({tag, ".empty"},  32'(if16.empty_o), 32'd1);
        chk({tag, ".aempty"}, 32'(if16.almost_empty_o), 32'd1);
        chk({tag, ".full"},   32'(if16.full_o), 32'd0);
        chk({tag, ".afull"},  32'(if16.almost_full_o), 32'd0);
        chk({tag, ".ovf"},    32'(if16.overflow_o), 32'd0);
        chk({tag, ".unf"},    32'(if16.underflow_o), 32'd0);
    endtask

    initial begin
        int pop;
        int pw;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_wr[i] = 1'b0; s_rd[i] = 1'b0; s_clr[i] = 1'b0; s_wd[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        d16(1'b0, 1'b0, 1'b0, 8'h00);
        chk_reset16("reset");
        chk("reset.d5.empty", 32'(if5.empty_o), 32'd1);

        // Fill the 16-deep FIFO with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            d16(1'b1, 1'b0, 1'b0, 8'(i));
            if (i == 13) chk("fill.afull13", 32'(if16.almost_full_o), 32'd0);
            if (i == 14) chk("fill.afull14", 32'(if16.almost_full_o), 32'd1);
            if (i == 15) chk("fill.full15", 32'(if16.full_o), 32'd0);
        end
        chk("fill.full", 32'(if16.full_o), 32'd1);
        chk("fill.level", 32'(if16.level_o), 32'd16);
        chk("fill.head", 32'(if16.r_data_o), 32'h01);

        // Simultaneous write/read while full.
        d16(1'b1, 1'b1, 1'b0, 8'hAA);
        chk("fullrw.level", 32'(if16.level_o), 32'd16);
        chk("fullrw.full", 32'(if16.full_o), 32'd1);
        chk("fullrw.ovf", 32'(if16.overflow_o), 32'd0);
        chk("fullrw.head", 32'(if16.r_data_o), 32'h02);

        // Rejected write while full.
        d16(1'b1, 1'b0, 1'b0, 8'hFF);
        chk("ovf.flag", 32'(if16.overflow_o), 32'd1);
        chk("ovf.level", 32'(if16.level_o), 32'd16);

        // Drain: 0x02..0x10 then 0xAA.
        for (int k = 0; k < 16; k++) begin
            chk("drain.data", 32'(if16.r_data_o), (k < 15) ? 32'(k + 2) : 32'hAA);
            d16(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("drain.empty", 32'(if16.empty_o), 32'd1);
        chk("drain.unf", 32'(if16.underflow_o), 32'd0);

        d16(1'b0, 1'b1, 1'b0, 8'h00);
        chk("unf.flag", 32'(if16.underflow_o), 32'd1);
        d16(1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr.unf", 32'(if16.underflow_o), 32'd0);
        chk("clr.ovf", 32'(if16.overflow_o), 32'd0);

        // Simultaneous write/read while empty.
        d16(1'b1, 1'b1, 1'b0, 8'h55);
        chk("emptyrw.level", 32'(if16.level_o), 32'd1);
        chk("emptyrw.data", 32'(if16.r_data_o), 32'h55);
        chk("emptyrw.unf", 32'(if16.underflow_o), 32'd1);

        // Flush with requests in the same cycle.
        d16(1'b1, 1'b1, 1'b1, 8'h77);
        chk_reset16("clrreq");

        // Depth=5: stream 12 words across the pointer wrap.
        pop = 0;
        for (int i = 0; i < 12; i++) begin
            if (i >= 3) chk("wrap.data", 32'(if5.r_data_o), 32'(8'h30 + pop));
            drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, (i >= 3), 1'b0, 8'(8'h30 + i));
            if (i >= 3) pop++;
        end
        chk("wrap.level", 32'(if5.level_o), 32'd3);
        while (pop < 12) begin
            chk("wrap.drain", 32'(if5.r_data_o), 32'(8'h30 + pop));
            drv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
            pop++;
        end
        chk("wrap.empty", 32'(if5.empty_o), 32'd1);

        // Random traffic with alternating fill/drain bias.
        for (int c = 0; c < 3000; c++) begin
            pw = ((c / 200) % 2 == 1) ? 75 : 30;
            drv(($urandom % 100) < pw, ($urandom % 100) < (100 - pw),
                ($urandom % 150) == 0, 8'($urandom),
                ($urandom % 100) < pw, ($urandom % 100) < (100 - pw),
                ($urandom % 150) == 0, 8'($urandom));
        end

        // Asynchronous reset mid-burst at level 7.
        drv(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) d16(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk("burst.level", 32'(if16.level_o), 32'd7);
        s_wr[0] = 1'b1;
        s_wd[0] = 8'h47;
        #2 rst = 1'b1;
        #1;
        chk_reset16("asyncrst");
        @(posedge clk);
        #1 rst = 1'b0;
        d16(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("post.data", 32'(if16.r_data_o), 32'h3C);
        chk("post.level", 32'(if16.level_o), 32'd1);
        d16(1'b0, 1'b1, 1'b0, 8'h00);
        chk("post.empty", 32'(if16.empty_o), 32'd1);
        chk("post.level0", 32'(if16.level_o), 32'd0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
